shift_reg_chain: RTL
====================

Name: shift_reg_chain

Overview:
- Parametrised shift register: DEPTH stages of WIDTH bits each, all on one clock.
- Supports hold, serial shift, parallel load and rotate modes.
- Provides a selectable tap, a parallel view of all stages, and a fill counter with a primed flag.
- Generic delay line / serialiser used wherever a fixed or variable pipeline delay is needed; with WIDTH=1, DEPTH=3, en=1, mode=SHIFT it is the three-flop serial chain.

Parameters:
- WIDTH, 1, bits per stage (>=1).
- DEPTH, 3, number of stages (>=1).
- RESET_VAL, 0, WIDTH-bit value loaded into every stage on reset.
- Derived constant TAP_W = (DEPTH>1) ? $clog2(DEPTH) : 1.
- Derived constant CNT_W = $clog2(DEPTH+1).

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high reset.
- en  in  1  stage update enable; 0 forces hold regardless of mode.
- mode  in  2  00 HOLD, 01 SHIFT, 10 LOAD, 11 ROTATE.
- d  in  WIDTH  serial input into stage 0.
- load_data  in  DEPTH*WIDTH  parallel load value; stage i = bits [i*WIDTH +: WIDTH].
- tap_sel  in  TAP_W  selects the stage driven onto tap_q.
- q  out  WIDTH  stage DEPTH-1 (serial output).
- tap_q  out  WIDTH  stage[tap_sel], combinational mux of registered stages.
- par_q  out  DEPTH*WIDTH  all stages, same packing as load_data.
- fill_cnt  out  CNT_W  number of valid stages, saturates at DEPTH.
- primed  out  1  fill_cnt == DEPTH.

Behaviour:
- All state updates on the rising edge of clk. Reset takes priority over everything.
- Reset: every stage = RESET_VAL; fill_cnt = 0; primed = 0. Hence q = tap_q = RESET_VAL and par_q = {DEPTH{RESET_VAL}}.
- en=0 or mode=HOLD: all stages and fill_cnt unchanged.
- SHIFT (en=1):
  - stage0 <= d; stage i <= stage i-1 for i=1..DEPTH-1.
  - fill_cnt <= min(fill_cnt+1, DEPTH).
- LOAD (en=1): stage i <= load_data slice i; fill_cnt <= DEPTH.
- ROTATE (en=1):
  - stage0 <= stage DEPTH-1; stage i <= stage i-1.
  - d is ignored; fill_cnt unchanged.
- Latency: a d value sampled on a SHIFT edge appears on q after DEPTH enabled SHIFT edges. Intervening HOLD or en=0 cycles stretch the latency and do not lose data.
- DEPTH=1: SHIFT is a single register; ROTATE is equivalent to HOLD; tap_sel is ignored and tap_q = q.
- tap_sel >= DEPTH (only possible when DEPTH is not a power of 2): tap_q = stage DEPTH-1.
- fill_cnt saturates at DEPTH and never wraps. primed stays 1 until reset.
- Reset asserted mid-stream: the next edge clears all state; in-flight data is discarded. First post-reset shift sets fill_cnt=1.
- Outputs q, par_q, fill_cnt and primed are registered or are direct wires from registers. Only tap_q passes through combinational logic (the mux).

Decomposition:
- Shared package shift_pkg holds:
  - mode encodings: MODE_HOLD=2'b00, MODE_SHIFT=2'b01, MODE_LOAD=2'b10, MODE_ROTATE=2'b11;
  - a typedef for mode.
- One sub-module, shift_stage, parameter WIDTH:
  - ports clk, reset, en, mode, shift_in, load_in, reset_val, q;
  - 3-way next-value mux plus register.
  - Instantiated DEPTH times in a generate loop with unique instance names.
  - shift_in = d for stage 0 in SHIFT, stage DEPTH-1 for stage 0 in ROTATE, stage i-1 otherwise.
- The top level owns the fill counter and the tap mux.

Test Plan:
1. WIDTH=1, DEPTH=3, en=1, SHIFT, d=1,0,1,1 on four edges after reset → q = 0,0,1,0,1 (sampled after edges 1–4 … 5); fill_cnt 1,2,3,3; primed asserts after edge 3.
2. WIDTH=8, DEPTH=4, LOAD load_data=0x44332211, then 4 ROTATE edges → par_q = 0x33221144, 0x22114433, 0x11443322, 0x44332211; fill_cnt=4 throughout.
3. WIDTH=8, DEPTH=4, SHIFT d=0xA5, then en=0 for 3 cycles, then 3 more SHIFT edges with d=0 → q=0xA5 only after the 4th enabled shift; no change during en=0.
4. DEPTH=5, par_q loaded 0x11..0x55, sweep tap_sel 0..7 → tap_q = 0x11,0x22,0x33,0x44,0x55,0x55,0x55,0x55.
5. RESET_VAL=8'hFF, shift 2 values, assert reset for 1 cycle mid-stream → all stages 0xFF, fill_cnt=0, primed=0; next SHIFT gives fill_cnt=1.
6. DEPTH=1, alternate SHIFT/ROTATE with d toggling → q follows d only on SHIFT edges, holds on ROTATE; tap_q == q.

Source files
------------

// File: rtl/shift_pkg.sv
// Shared definitions for the shift register chain: operating-mode encodings.
package shift_pkg;

  typedef enum logic [1:0] {
    MODE_HOLD   = 2'b00,
    MODE_SHIFT  = 2'b01,
    MODE_LOAD   = 2'b10,
    MODE_ROTATE = 2'b11
  } mode_t;

endpackage

// File: rtl/shift_stage.sv
// One WIDTH-bit stage of the chain: hold / shift-or-rotate input / parallel load.
module shift_stage
  import shift_pkg::*;
#(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] shift_in,
  input  logic [WIDTH-1:0] load_in,
  input  logic [WIDTH-1:0] reset_val,
  output logic [WIDTH-1:0] q
);

  mode_t mode_e;
  assign mode_e = mode_t'(mode);

  // SHIFT and ROTATE differ only in what the parent feeds onto shift_in.
  always_ff @(posedge clk) begin
    if (reset) begin
      q <= reset_val;
    end else if (en) begin
      case (mode_e)
        MODE_SHIFT, MODE_ROTATE: q <= shift_in;
        MODE_LOAD:               q <= load_in;
        default:                 q <= q;
      endcase
    end
  end

endmodule

// File: rtl/shift_reg_chain.sv
// Parametrised DEPTH x WIDTH shift register with hold/shift/load/rotate modes,
// a selectable tap, a parallel view and a saturating fill counter.
module shift_reg_chain
  import shift_pkg::*;
#(
  parameter int               WIDTH     = 1,
  parameter int               DEPTH     = 3,
  parameter logic [WIDTH-1:0] RESET_VAL = '0,
  localparam int              TAP_W     = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int              CNT_W     = $clog2(DEPTH + 1)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   en,
  input  logic [1:0]             mode,
  input  logic [WIDTH-1:0]       d,
  input  logic [DEPTH*WIDTH-1:0] load_data,
  input  logic [TAP_W-1:0]       tap_sel,
  output logic [WIDTH-1:0]       q,
  output logic [WIDTH-1:0]       tap_q,
  output logic [DEPTH*WIDTH-1:0] par_q,
  output logic [CNT_W-1:0]       fill_cnt,
  output logic                   primed
);

  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  mode_t            mode_e;
  logic [WIDTH-1:0] stage [DEPTH];
  logic [CNT_W-1:0] cnt_next;

  assign mode_e = mode_t'(mode);

  for (genvar i = 0; i < DEPTH; i++) begin : g_stage
    logic [WIDTH-1:0] shift_in;

    // Stage 0 takes d when shifting and wraps the last stage when rotating.
    if (i == 0) begin : g_head
      assign shift_in = (mode_e == MODE_ROTATE) ? stage[DEPTH-1] : d;
    end else begin : g_body
      assign shift_in = stage[i-1];
    end

    shift_stage #(
      .WIDTH (WIDTH)
    ) u_stage (
      .clk       (clk),
      .reset     (reset),
      .en        (en),
      .mode      (mode),
      .shift_in  (shift_in),
      .load_in   (load_data[i*WIDTH +: WIDTH]),
      .reset_val (RESET_VAL),
      .q         (stage[i])
    );

    assign par_q[i*WIDTH +: WIDTH] = stage[i];
  end

  assign q = stage[DEPTH-1];

  // Out-of-range selects fall back to the last stage.
  always_comb begin
    tap_q = stage[DEPTH-1];
    for (int i = 0; i < DEPTH; i++) begin
      if (tap_sel == TAP_W'(i)) tap_q = stage[i];
    end
  end

  always_comb begin
    cnt_next = fill_cnt;
    if (en) begin
      case (mode_e)
        MODE_SHIFT: if (fill_cnt != FULL_CNT) cnt_next = fill_cnt + CNT_W'(1);
        MODE_LOAD:  cnt_next = FULL_CNT;
        default:    cnt_next = fill_cnt;
      endcase
    end
  end

  // primed is registered from the next count so it is a plain flop output.
  always_ff @(posedge clk) begin
    if (reset) begin
      fill_cnt <= '0;
      primed   <= 1'b0;
    end else begin
      fill_cnt <= cnt_next;
      primed   <= (cnt_next == FULL_CNT);
    end
  end

endmodule
